set_ram_access_scheduler: RTL and testbench

Sequences and shares one single-port set RAM (1-cycle registered read, write-enable qualified by access-enable) between a lookup requester (read-only) and an update requester (write-only). After reset, and on request, it sweeps every set to zero before any requester is served. It sits between the cache pipeline's lookup/update stages and the per-array set RAM instance, and owns all of that RAM's control inputs.

---
 rtl/set_ram_access_scheduler_if.sv | 57 +++++
 rtl/set_ram_access_scheduler.sv | 108 ++++++++++
 tb/tb_set_ram_access_scheduler.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/set_ram_access_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | set_ram_access_scheduler_if                                                |
// | Requester and set-RAM control bundle for set_ram_access_scheduler.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface set_ram_access_scheduler_if #(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 10,
  parameter int SET_PTR_WIDTH_IN_BITS       = 6
);
  logic                                   flush_in;

  logic                                   lookup_valid_in;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]       lookup_set_addr_in;
  logic                                   lookup_ready_out;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] lookup_element_out;
  logic                                   lookup_element_valid_out;

  logic                                   update_valid_in;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]       update_set_addr_in;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] update_element_in;
  logic                                   update_ready_out;
  logic                                   update_done_out;

  logic                                   init_done_out;

  logic                                   ram_access_en_out;
  logic                                   ram_write_en_out;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_set_addr_out;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_write_element_out;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_read_element_in;

  // Scheduler side
  modport slave (
    input  flush_in,
    input  lookup_valid_in, lookup_set_addr_in,
    output lookup_ready_out, lookup_element_out, lookup_element_valid_out,
    input  update_valid_in, update_set_addr_in, update_element_in,
    output update_ready_out, update_done_out,
    output init_done_out,
    output ram_access_en_out, ram_write_en_out, ram_set_addr_out, ram_write_element_out,
    input  ram_read_element_in
  );

  // Pipeline / RAM side
  modport master (
    output flush_in,
    output lookup_valid_in, lookup_set_addr_in,
    input  lookup_ready_out, lookup_element_out, lookup_element_valid_out,
    output update_valid_in, update_set_addr_in, update_element_in,
    input  update_ready_out, update_done_out,
    input  init_done_out,
    input  ram_access_en_out, ram_write_en_out, ram_set_addr_out, ram_write_element_out,
    output ram_read_element_in
  );
endinterface
`default_nettype wire

// File: rtl/set_ram_access_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | set_ram_access_scheduler                                                   |
// | Zero-sweeps a single-port set RAM, then round-robins lookup/update access.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module set_ram_access_scheduler #(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 10,
  parameter int NUMBER_SETS                 = 64,
  parameter int SET_PTR_WIDTH_IN_BITS       = 6
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  set_ram_access_scheduler_if.slave bus
);

  localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUMBER_SETS - 1);
  localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] ONE_SET  = SET_PTR_WIDTH_IN_BITS'(1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                           state_q;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] sweep_cnt_q;
  logic                             prio_update_q;
  logic                             lookup_valid_q;
  logic                             update_done_q;
  logic                             init_done_q;

  logic                             sweeping;
  logic                             serve;
  logic                             lookup_grant;
  logic                             update_grant;

  // Reset gates every control output so no RAM access escapes while it is held.
  assign sweeping     = !reset_in && (state_q == ST_INIT);
  assign serve        = !reset_in && (state_q == ST_RUN) && !bus.flush_in;
  assign lookup_grant = serve && bus.lookup_valid_in && (!bus.update_valid_in || !prio_update_q);
  assign update_grant = serve && bus.update_valid_in && (!bus.lookup_valid_in ||  prio_update_q);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q        <= ST_INIT;
      sweep_cnt_q    <= '0;
      prio_update_q  <= 1'b0;
      lookup_valid_q <= 1'b0;
      update_done_q  <= 1'b0;
      init_done_q    <= 1'b0;
    end else begin
      lookup_valid_q <= lookup_grant;
      update_done_q  <= update_grant;
      if (lookup_grant) begin
        prio_update_q <= 1'b1;
      end else if (update_grant) begin
        prio_update_q <= 1'b0;
      end
      case (state_q)
        ST_INIT: begin
          if (sweep_cnt_q == LAST_SET) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end else begin
            sweep_cnt_q <= sweep_cnt_q + ONE_SET;
          end
        end
        ST_RUN: begin
          if (bus.flush_in) begin
            state_q     <= ST_INIT;
            sweep_cnt_q <= '0;
            init_done_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_INIT;
          sweep_cnt_q <= '0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.ram_set_addr_out      = '0;
    bus.ram_write_element_out = '0;
    if (state_q == ST_INIT) begin
      bus.ram_set_addr_out = sweep_cnt_q;
    end else if (lookup_grant) begin
      bus.ram_set_addr_out = bus.lookup_set_addr_in;
    end else if (update_grant) begin
      bus.ram_set_addr_out      = bus.update_set_addr_in;
      bus.ram_write_element_out = bus.update_element_in;
    end
  end

  assign bus.ram_access_en_out        = sweeping | lookup_grant | update_grant;
  assign bus.ram_write_en_out         = sweeping | update_grant;

  assign bus.lookup_ready_out         = lookup_grant;
  assign bus.update_ready_out         = update_grant;
  assign bus.lookup_element_out       = bus.ram_read_element_in;
  assign bus.lookup_element_valid_out = lookup_valid_q;
  assign bus.update_done_out          = update_done_q;
  assign bus.init_done_out            = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_set_ram_access_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_set_ram_access_scheduler                                                |
// | Directed self-checking bench with a behavioural single-port set RAM.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_set_ram_access_scheduler;

  localparam int EW = 10;
  localparam int NS = 64;
  localparam int AW = 6;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  set_ram_access_scheduler_if #(
    .SINGLE_ELEMENT_SIZE_IN_BITS(EW),
    .SET_PTR_WIDTH_IN_BITS      (AW)
  ) bus ();

  set_ram_access_scheduler #(
    .SINGLE_ELEMENT_SIZE_IN_BITS(EW),
    .NUMBER_SETS                (NS),
    .SET_PTR_WIDTH_IN_BITS      (AW)
  ) dut (
    .clk_in  (clk),
    .reset_in(rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: registered read, write qualified by access enable.
  logic [EW-1:0] mem [NS];
  always @(posedge clk) begin
    if (bus.ram_access_en_out) begin
      if (bus.ram_write_en_out) mem[bus.ram_set_addr_out] <= bus.ram_write_element_out;
      else                      bus.ram_read_element_in   <= mem[bus.ram_set_addr_out];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ram_obs();
    return 32'({bus.ram_access_en_out, bus.ram_write_en_out,
                bus.ram_set_addr_out, bus.ram_write_element_out});
  endfunction

  function automatic logic [31:0] ram_exp(input logic en, input logic we,
                                          input logic [AW-1:0] a, input logic [EW-1:0] d);
    return 32'({en, we, a, d});
  endfunction

  function automatic logic [31:0] grants();
    return 32'({bus.lookup_ready_out, bus.update_ready_out});
  endfunction

  function automatic logic [31:0] pulses();
    return 32'({bus.lookup_element_valid_out, bus.update_done_out});
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush_in           = 1'b0;
    bus.lookup_valid_in    = 1'b0;
    bus.lookup_set_addr_in = '0;
    bus.update_valid_in    = 1'b0;
    bus.update_set_addr_in = '0;
    bus.update_element_in  = '0;
  endtask

  // Called in sweep cycle 0; returns at the start of cycle NS.
  task automatic sweep(input logic hold);
    for (int k = 0; k < NS; k++) begin
      if (k != 0) cyc();
      bus.lookup_valid_in = hold;
      bus.update_valid_in = hold;
      #1;
      check("sweep_ram", ram_obs(), ram_exp(1'b1, 1'b1, AW'(k), '0));
      check("sweep_init_low", 32'(bus.init_done_out), 32'd0);
      check("sweep_no_ready", grants(), 32'd0);
    end
    cyc();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle();
    bus.lookup_valid_in = 1'b1;
    bus.update_valid_in = 1'b1;
    repeat (3) cyc();
    #1;
    check("rst_ready", grants(), 32'd0);
    check("rst_ram_en", 32'({bus.ram_access_en_out, bus.ram_write_en_out}), 32'd0);
    check("rst_regs", 32'({pulses(), bus.init_done_out}), 32'd0);

    // Power-up sweep, then a lookup of a swept set
    cyc();
    rst = 1'b0;
    idle();
    sweep(1'b0);
    bus.lookup_valid_in    = 1'b1;
    bus.lookup_set_addr_in = 6'd37;
    #1;
    check("init_done_c64", 32'(bus.init_done_out), 32'd1);
    check("lk37_grant", grants(), 32'b10);
    check("lk37_ram", ram_obs(), ram_exp(1'b1, 1'b0, 6'd37, '0));
    cyc();
    idle();
    #1;
    check("lk37_pulse", pulses(), 32'b10);
    check("lk37_data", 32'(bus.lookup_element_out), 32'h0);

    // Write then read-back of the same set
    bus.update_valid_in    = 1'b1;
    bus.update_set_addr_in = 6'd5;
    bus.update_element_in  = 10'h2AB;
    #1;
    check("up5_grant", grants(), 32'b01);
    check("up5_ram", ram_obs(), ram_exp(1'b1, 1'b1, 6'd5, 10'h2AB));
    cyc();
    idle();
    bus.lookup_valid_in    = 1'b1;
    bus.lookup_set_addr_in = 6'd5;
    #1;
    check("up5_done", pulses(), 32'b01);
    check("lk5_grant", grants(), 32'b10);
    cyc();
    idle();
    #1;
    check("lk5_pulse", pulses(), 32'b10);
    check("lk5_data", 32'(bus.lookup_element_out), 32'h2AB);

    // Flush clears a written set
    bus.update_valid_in    = 1'b1;
    bus.update_set_addr_in = 6'd9;
    bus.update_element_in  = 10'h155;
    #1;
    check("up9_grant", grants(), 32'b01);
    cyc();
    idle();
    bus.flush_in           = 1'b1;
    bus.lookup_valid_in    = 1'b1;
    bus.lookup_set_addr_in = 6'd9;
    #1;
    check("flush_no_grant", grants(), 32'd0);
    check("flush_ram_idle", 32'({bus.ram_access_en_out, bus.ram_write_en_out}), 32'd0);
    check("flush_init_high", 32'(bus.init_done_out), 32'd1);
    cyc();
    idle();
    sweep(1'b0);
    bus.lookup_valid_in    = 1'b1;
    bus.lookup_set_addr_in = 6'd9;
    #1;
    check("post_flush_init", 32'(bus.init_done_out), 32'd1);
    check("lk9_grant", grants(), 32'b10);
    cyc();
    idle();
    #1;
    check("lk9_pulse", pulses(), 32'b10);
    check("lk9_data", 32'(bus.lookup_element_out), 32'h0);

    // Reset at sweep count 20: sweep restarts from 0
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k != 0) cyc();
      #1;
      check("part_sweep", ram_obs(), ram_exp(1'b1, 1'b1, AW'(k), '0));
    end
    cyc();
    #1;
    check("sweep_at20", ram_obs(), ram_exp(1'b1, 1'b1, 6'd20, '0));
    rst = 1'b1;
    #1;
    check("rst20_ram_en", 32'({bus.ram_access_en_out, bus.ram_write_en_out}), 32'd0);
    cyc();
    rst = 1'b0;
    bus.lookup_set_addr_in = 6'd3;
    bus.update_set_addr_in = 6'd4;
    bus.update_element_in  = 10'h0F0;
    sweep(1'b1);

    // Continuous contention alternates, starting with lookup
    for (int i = 0; i < 6; i++) begin
      if (i != 0) cyc();
      bus.lookup_valid_in = 1'b1;
      bus.update_valid_in = 1'b1;
      #1;
      check("rr_grant", grants(), (i % 2 == 0) ? 32'b10 : 32'b01);
    end
    cyc();
    bus.lookup_valid_in = 1'b0;
    #1;
    check("rr_solo_update", grants(), 32'b01);
    cyc();
    bus.lookup_valid_in = 1'b1;
    #1;
    check("rr_favour_lookup", grants(), 32'b10);

    // Reset on a requested lookup: no grant, no later valid pulse
    cyc();
    bus.update_valid_in = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_lk_grant", grants(), 32'd0);
    check("rst_lk_ram_en", 32'({bus.ram_access_en_out, bus.ram_write_en_out}), 32'd0);
    cyc();
    rst = 1'b0;
    idle();
    #1;
    check("rst_lk_no_pulse", pulses(), 32'd0);
    sweep(1'b0);
    #1;
    check("final_init", 32'(bus.init_done_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
